// File: rtl/alu_wb_stage.sv
// alu_wb_stage: execute-to-writeback stage behind the BCD/arithmetic ALU.
// Holds up to two results in a skid buffer under valid/ready.
// It also owns the committed PSW, which is updated when a result is accepted.
// Optional macro PSW_FWD_EN: carry_fb bypasses the PSW register on an accept
// cycle so that carry-chained ops can issue back to back.
module alu_wb_stage #(
  parameter int          DEPTH   = 2,
  parameter logic [15:0] PSW_RST = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] alu_result,
  input  logic [15:0] alu_psw_out,
  input  logic [15:0] alu_psw_msk,
  input  logic [2:0]  dst_reg,
  input  logic        wr_en,
  input  logic        byte_op,
  input  logic        psw_wr,
  input  logic [15:0] psw_wdata,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] wb_data,
  output logic [2:0]  wb_reg,
  output logic        wb_en,
  output logic        wb_byte,
  output logic [15:0] psw,
  output logic        carry_fb
);

  // The pointer and count widths assume exactly two entries.
  if (DEPTH != 2) begin : g_depth_chk
    $error("alu_wb_stage: DEPTH must be 2");
  end

  logic [1:0][15:0] data_q;
  logic [1:0][2:0]  reg_q;
  logic [1:0]       en_q, byte_q;
  logic             rd_ptr_q, wr_ptr_q;
  logic [1:0]       count_q, count_d;
  logic [15:0]      psw_q, psw_d;
  logic             push, pop;

  // Handshake decode. in_ready and out_valid come only from count_q, so there
  // is no combinational path from any input to either of them.
  always_comb begin
    in_ready  = (count_q != 2'd2);
    out_valid = (count_q != 2'd0);
    push      = in_valid && in_ready && !flush;
    pop       = out_valid && out_ready;
    count_d   = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Next PSW. An explicit write wins over an ALU merge in the same cycle.
  // A push dropped by flush contributes no merge.
  always_comb begin
    psw_d = psw_q;
    if (psw_wr)
      psw_d = psw_wdata;
    else if (push)
      psw_d = (psw_q & ~alu_psw_msk) | (alu_psw_out & alu_psw_msk);
  end

  // Skid buffer storage, pointers and occupancy. Flush empties the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q   <= '0;
      reg_q    <= '0;
      en_q     <= '0;
      byte_q   <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        data_q[wr_ptr_q] <= alu_result;
        reg_q[wr_ptr_q]  <= dst_reg;
        en_q[wr_ptr_q]   <= wr_en;
        byte_q[wr_ptr_q] <= byte_op;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop)
        rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  // Committed PSW register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) psw_q <= PSW_RST;
    else        psw_q <= psw_d;
  end

  // Head-entry presentation. The outputs are forced to zero while empty.
  always_comb begin
    wb_data = out_valid ? data_q[rd_ptr_q] : 16'h0000;
    wb_reg  = out_valid ? reg_q[rd_ptr_q]  : 3'd0;
    wb_en   = out_valid & en_q[rd_ptr_q];
    wb_byte = out_valid & byte_q[rd_ptr_q];
    psw     = psw_q;
  end

  // Carry feedback to the ALU: bypassed on accept, or from the register.
  always_comb begin
`ifdef PSW_FWD_EN
    carry_fb = psw_d[0];
`else
    carry_fb = psw_q[0];
`endif
  end

endmodule

// File: tb/tb_alu_wb_stage.sv
// Scoreboard bench for alu_wb_stage. The stimulus process records expected
// writebacks in an indexed queue. The monitor process pops entries on every
// out_valid && out_ready and also runs status checks requested by the
// stimulus process.
module tb_alu_wb_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [15:0] alu_result, alu_psw_out, alu_psw_msk;
  logic [2:0]  dst_reg;
  logic        wr_en, byte_op, psw_wr, flush;
  logic [15:0] psw_wdata;
  logic        out_valid, out_ready;
  logic [15:0] wb_data;
  logic [2:0]  wb_reg;
  logic        wb_en, wb_byte;
  logic [15:0] psw;
  logic        carry_fb;

  alu_wb_stage #(.DEPTH(2), .PSW_RST(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .alu_psw_out(alu_psw_out), .alu_psw_msk(alu_psw_msk),
    .dst_reg(dst_reg), .wr_en(wr_en), .byte_op(byte_op), .psw_wr(psw_wr),
    .psw_wdata(psw_wdata), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .wb_data(wb_data), .wb_reg(wb_reg), .wb_en(wb_en),
    .wb_byte(wb_byte), .psw(psw), .carry_fb(carry_fb)
  );

  always #5 clk = ~clk;

`ifdef PSW_FWD_EN
  localparam logic FWD = 1'b1;
`else
  localparam logic FWD = 1'b0;
`endif

  // Expected writeback queue: wi is written by stimulus, ri by the monitor.
  logic [15:0] q_data [64];
  logic [2:0]  q_reg  [64];
  logic        q_en   [64];
  logic        q_byte [64];
  int          wi = 0;
  int          ri = 0;

  // Status check request from stimulus. Bits: 0 psw, 1 carry, 2 in_ready,
  // 3 out_valid, 4 queue drained.
  logic [4:0]  chk_en = '0;
  logic [15:0] e_psw;
  logic        e_c, e_rdy, e_ov;

  int n_chk  = 0;
  int n_fail = 0;

  // Monitor: compare on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      n_chk++;
      if (ri >= wi) begin
        n_fail++;
        $display("FAIL wb_unexpected: got data=%h reg=%0d, scoreboard empty", wb_data, wb_reg);
      end else begin
        if ({wb_data, wb_reg, wb_en, wb_byte} !== {q_data[ri], q_reg[ri], q_en[ri], q_byte[ri]}) begin
          n_fail++;
          $display("FAIL wb_entry%0d: got data=%h reg=%0d en=%b byte=%b want data=%h reg=%0d en=%b byte=%b",
                   ri, wb_data, wb_reg, wb_en, wb_byte, q_data[ri], q_reg[ri], q_en[ri], q_byte[ri]);
        end
        ri++;
      end
    end
    if (out_valid === 1'b0) begin
      n_chk++;
      if ({wb_data, wb_reg, wb_en, wb_byte} !== 21'd0) begin
        n_fail++;
        $display("FAIL wb_idle_zero: got data=%h reg=%0d en=%b byte=%b want all 0",
                 wb_data, wb_reg, wb_en, wb_byte);
      end
    end
    if (chk_en[0]) begin
      n_chk++;
      if (psw !== e_psw) begin n_fail++; $display("FAIL psw: got %h want %h", psw, e_psw); end
    end
    if (chk_en[1]) begin
      n_chk++;
      if (carry_fb !== e_c) begin n_fail++; $display("FAIL carry_fb: got %b want %b", carry_fb, e_c); end
    end
    if (chk_en[2]) begin
      n_chk++;
      if (in_ready !== e_rdy) begin n_fail++; $display("FAIL in_ready: got %b want %b", in_ready, e_rdy); end
    end
    if (chk_en[3]) begin
      n_chk++;
      if (out_valid !== e_ov) begin n_fail++; $display("FAIL out_valid: got %b want %b", out_valid, e_ov); end
    end
    if (chk_en[4]) begin
      n_chk++;
      if (ri != wi) begin n_fail++; $display("FAIL drain: got %0d popped want %0d", ri, wi); end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Requests a status check at the next falling edge.
  task automatic status(input logic [4:0] en, input logic [15:0] p, input logic c,
                        input logic r, input logic o);
    e_psw = p; e_c = c; e_rdy = r; e_ov = o; chk_en = en;
    @(negedge clk); #1;
    chk_en = '0;
  endtask

  task automatic idle();
    in_valid = 0; psw_wr = 0; flush = 0; alu_psw_msk = '0; alu_psw_out = '0;
  endtask

  // Drives an ALU op for the current cycle. rec records it as a writeback.
  task automatic drive(input logic [15:0] d, input logic [15:0] msk, input logic [15:0] po,
                       input logic [2:0] r, input logic we, input logic bo, input logic rec);
    in_valid = 1; alu_result = d; alu_psw_msk = msk; alu_psw_out = po;
    dst_reg = r; wr_en = we; byte_op = bo;
    if (rec) begin
      q_data[wi] = d; q_reg[wi] = r; q_en[wi] = we; q_byte[wi] = bo; wi++;
    end
  endtask

  initial begin
    rst_n = 0; out_ready = 0; alu_result = '0; dst_reg = '0; wr_en = 0;
    byte_op = 0; psw_wdata = '0;
    idle();
    // Reset state
    status(5'b01111, 16'h0000, 1'b0, 1'b1, 1'b0);
    tick(); rst_n = 1; tick();

    // Single push, with carry visible in the accept cycle only when forwarded
    out_ready = 1;
    drive(16'h1234, 16'h0013, 16'h0001, 3'd3, 1, 0, 1);
    status(5'b00010, 16'h0, FWD, 1'b0, 1'b0);
    tick(); idle();
    status(5'b01111, 16'h0001, 1'b1, 1'b1, 1'b1);
    tick();
    status(5'b01100, 16'h0, 1'b0, 1'b1, 1'b0);

    // Backpressure: fill to 2, the third push is ignored (it would clear C)
    tick(); out_ready = 0;
    drive(16'h0099, 16'h0000, 16'h0000, 3'd1, 1, 0, 1); tick();
    drive(16'h0100, 16'h0000, 16'h0000, 3'd2, 1, 1, 1); tick(); idle();
    status(5'b01101, 16'h0001, 1'b0, 1'b0, 1'b1);
    drive(16'hDEAD, 16'h0001, 16'h0000, 3'd5, 1, 0, 0); tick(); idle();
    status(5'b01111, 16'h0001, 1'b1, 1'b0, 1'b1);
    tick(); out_ready = 1; tick(); tick();
    status(5'b01100, 16'h0, 1'b0, 1'b1, 1'b0);

    // Masked merge: 00FF with mask 0003 and value 0002 gives 00FE
    tick(); psw_wr = 1; psw_wdata = 16'h00FF; tick(); idle();
    status(5'b00011, 16'h00FF, 1'b1, 1'b0, 1'b0);
    drive(16'h5555, 16'h0003, 16'h0002, 3'd4, 0, 0, 1); tick(); idle();
    status(5'b00011, 16'h00FE, 1'b0, 1'b0, 1'b0);

    // psw_wr collides with an ALU merge; the entry is still written back
    tick();
    drive(16'h7777, 16'h0001, 16'h0001, 3'd6, 1, 0, 1);
    psw_wr = 1; psw_wdata = 16'h0010;
    status(5'b00010, 16'h0, 1'b0, 1'b0, 1'b0);
    tick(); idle();
    status(5'b01011, 16'h0010, 1'b0, 1'b0, 1'b1);

    // Flush with a full buffer, with a push offered and a psw_wr in the same cycle
    tick(); tick(); out_ready = 0;
    drive(16'h1111, 16'h0000, 16'h0000, 3'd1, 1, 0, 0); tick();
    drive(16'h2222, 16'h0000, 16'h0000, 3'd2, 1, 0, 0); tick();
    drive(16'h3333, 16'h0001, 16'h0001, 3'd3, 1, 0, 0);
    flush = 1; psw_wr = 1; psw_wdata = 16'h0020; tick(); idle();
    status(5'b01101, 16'h0020, 1'b0, 1'b1, 1'b0);
    // Flush with one entry; the same-cycle push and its merge are dropped
    drive(16'h4444, 16'h0000, 16'h0000, 3'd4, 1, 0, 0); tick();
    drive(16'h5050, 16'h0004, 16'h0004, 3'd5, 1, 0, 0);
    flush = 1; tick(); idle();
    status(5'b01101, 16'h0020, 1'b0, 1'b1, 1'b0);
    // The stage still works after a flush
    out_ready = 1;
    drive(16'h4321, 16'h0000, 16'h0000, 3'd7, 1, 1, 1); tick(); idle(); tick();

    // Async reset between edges while the buffer is full
    out_ready = 0;
    drive(16'hAAAA, 16'h0001, 16'h0001, 3'd1, 1, 0, 0); tick();
    drive(16'hBBBB, 16'h0000, 16'h0000, 3'd2, 1, 0, 0); tick(); idle();
    status(5'b01111, 16'h0021, 1'b1, 1'b0, 1'b1);
    #2 rst_n = 0;
    status(5'b01111, 16'h0000, 1'b0, 1'b1, 1'b0);
    tick(); rst_n = 1; tick();
    out_ready = 1;
    drive(16'h0F0F, 16'h0004, 16'h0004, 3'd0, 1, 0, 1); tick(); idle();
    status(5'b01001, 16'h0004, 1'b0, 1'b0, 1'b1);

    // Drain, with a bounded wait
    for (int i = 0; i < 20 && ri != wi; i++) tick();
    status(5'b10000, 16'h0, 1'b0, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
